// File: rtl/bandwidth_gear_controller.sv
// Loop-bandwidth gear controller: steps wide -> mid -> narrow as the
// phase error settles, and drops back to wide on loss of lock.
module bandwidth_gear_controller #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        err_valid,
    input  logic [15:0] phase_err,
    input  logic [15:0] lock_thresh,
    input  logic [15:0] unlock_thresh,
    output logic [1:0]  gear,
    output logic        lock_status,
    output logic        gear_chg,
    output logic [7:0]  loss_count
);

    typedef enum logic [1:0] {
        S_IDLE, S_ACQUIRE, S_SETTLE, S_LOCKED
    } state_t;

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_in_cnt;
    logic [7:0]  w_in_nxt;
    logic [7:0]  r_out_cnt;
    logic [7:0]  w_out_nxt;
    logic [7:0]  r_loss;
    logic [7:0]  w_loss_nxt;
    logic [1:0]  r_gear;
    logic [1:0]  w_gear_nxt;
    logic        r_lock;
    logic        r_chg;
    logic [15:0] w_neg;
    logic [15:0] w_mag;
    logic        w_in;
    logic        w_out;
    logic        w_in_last;
    logic        w_out_last;

    // -32768 has no positive counterpart, so it clamps to 32767
    assign w_neg = -phase_err;
    assign w_mag = !phase_err[15]         ? phase_err :
                   (phase_err == 16'h8000) ? 16'h7fff  : w_neg;

    assign w_in       = err_valid && (w_mag <= lock_thresh);
    assign w_out      = err_valid && (w_mag > unlock_thresh);
    assign w_in_last  = (r_in_cnt >= LOCK_LAST);
    assign w_out_last = (r_out_cnt >= UNLOCK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_in_nxt    = r_in_cnt;
        w_out_nxt   = r_out_cnt;
        w_loss_nxt  = r_loss;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_in_nxt    = 8'd0;
            w_out_nxt   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ACQUIRE;
                    w_in_nxt    = 8'd0;
                    w_out_nxt   = 8'd0;
                end
                S_ACQUIRE, S_SETTLE: begin
                    // in-qualification wins even if thresholds overlap
                    if (w_in) begin
                        if (w_in_last) begin
                            w_in_nxt    = 8'd0;
                            w_out_nxt   = 8'd0;
                            w_state_nxt = (r_state == S_ACQUIRE) ?
                                          S_SETTLE : S_LOCKED;
                        end else begin
                            w_in_nxt = r_in_cnt + 8'd1;
                        end
                    end else if (err_valid) begin
                        w_in_nxt = 8'd0;
                        if (w_out && r_state == S_SETTLE)
                            w_state_nxt = S_ACQUIRE;
                    end
                end
                S_LOCKED: begin
                    if (w_out) begin
                        if (w_out_last) begin
                            w_state_nxt = S_ACQUIRE;
                            w_in_nxt    = 8'd0;
                            w_out_nxt   = 8'd0;
                            if (r_loss != 8'hff)
                                w_loss_nxt = r_loss + 8'd1;
                        end else begin
                            w_out_nxt = r_out_cnt + 8'd1;
                        end
                    end else if (err_valid) begin
                        w_out_nxt = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_in_nxt    = 8'd0;
                    w_out_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        case (w_state_nxt)
            S_SETTLE: w_gear_nxt = 2'd1;
            S_LOCKED: w_gear_nxt = 2'd2;
            default:  w_gear_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_in_cnt  <= 8'd0;
            r_out_cnt <= 8'd0;
            r_loss    <= 8'd0;
            r_gear    <= 2'd0;
            r_lock    <= 1'b0;
            r_chg     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_in_cnt  <= w_in_nxt;
            r_out_cnt <= w_out_nxt;
            r_loss    <= w_loss_nxt;
            r_gear    <= w_gear_nxt;
            r_lock    <= (w_state_nxt == S_LOCKED);
            r_chg     <= (w_gear_nxt != r_gear);
        end
    end

    assign gear        = r_gear;
    assign lock_status = r_lock;
    assign gear_chg    = r_chg;
    assign loss_count  = r_loss;

endmodule

// File: tb/tb_bandwidth_gear_controller.sv
// Directed and randomized checks of bandwidth_gear_controller against
// a sample-level behavioural model.
module tb_bandwidth_gear_controller;

    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_CNT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        err_valid;
    logic [15:0] phase_err;
    logic [15:0] lock_thresh;
    logic [15:0] unlock_thresh;
    logic [1:0]  gear;
    logic        lock_status;
    logic        gear_chg;
    logic [7:0]  loss_count;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 acquire, 2 settle, 3 locked
    int m_ph, m_in, m_out, m_loss, m_gear, m_chg;

    bandwidth_gear_controller #(
        .LOCK_CNT(LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .err_valid(err_valid),
        .phase_err(phase_err),
        .lock_thresh(lock_thresh),
        .unlock_thresh(unlock_thresh),
        .gear(gear),
        .lock_status(lock_status),
        .gear_chg(gear_chg),
        .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_in = 0; m_out = 0;
        m_loss = 0; m_gear = 0; m_chg = 0;
    endtask

    task automatic model_edge(input logic en, input logic v,
                              input logic [15:0] pe);
        int e, mag, old_gear;
        e = int'($signed(pe));
        mag = (e < 0) ? -e : e;
        if (mag > 32767) mag = 32767;
        old_gear = m_gear;
        if (!en) begin
            m_ph = 0; m_in = 0; m_out = 0;
        end else if (m_ph == 0) begin
            m_ph = 1; m_in = 0; m_out = 0;
        end else if (v && (m_ph == 1 || m_ph == 2)) begin
            if (mag <= int'(lock_thresh)) begin
                m_in++;
                if (m_in == LOCK_CNT) begin
                    m_in = 0; m_out = 0; m_ph++;
                end
            end else begin
                m_in = 0;
                if (m_ph == 2 && mag > int'(unlock_thresh)) m_ph = 1;
            end
        end else if (v && m_ph == 3) begin
            if (mag > int'(unlock_thresh)) begin
                m_out++;
                if (m_out == UNLOCK_CNT) begin
                    m_ph = 1; m_in = 0; m_out = 0;
                    if (m_loss < 255) m_loss++;
                end
            end else begin
                m_out = 0;
            end
        end
        m_gear = (m_ph == 3) ? 2 : (m_ph == 2) ? 1 : 0;
        m_chg = (m_gear != old_gear) ? 1 : 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_gear"}, 32'(gear), m_gear);
        chk({tag, "_lock"}, 32'(lock_status), (m_ph == 3) ? 1 : 0);
        chk({tag, "_chg"}, 32'(gear_chg), m_chg);
        chk({tag, "_loss"}, 32'(loss_count), m_loss);
    endtask

    task automatic step(input logic en, input logic v,
                        input logic [15:0] pe);
        enable = en; err_valid = v; phase_err = pe;
        @(posedge clk);
        model_edge(en, v, pe);
        #1;
        check_all("step");
    endtask

    task automatic samples(input int n, input logic [15:0] pe);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, pe);
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst_zero", {gear, lock_status, gear_chg, loss_count}, 0);
        @(posedge clk);
        #1;
        check_all("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; err_valid = 1'b0; phase_err = '0;
        lock_thresh = 16'd100; unlock_thresh = 16'd400;
        model_reset();
        #1;
        check_all("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b1, 16'd50);
        chk("idle_hold_gear", 32'(gear), 0);

        step(1'b1, 1'b0, 16'd0);
        samples(16, 16'd50);
        chk("upshift1_gear", 32'(gear), 1);
        chk("upshift1_chg", 32'(gear_chg), 1);
        samples(16, 16'd50);
        chk("upshift2_gear", 32'(gear), 2);
        chk("upshift2_lock", 32'(lock_status), 1);

        samples(2, 16'd500);
        samples(1, 16'd300);
        chk("loss_hold_lock", 32'(lock_status), 1);
        samples(3, 16'd500);
        chk("loss_lock", 32'(lock_status), 1);
        samples(1, 16'd500);
        chk("loss_gear", 32'(gear), 0);
        chk("loss_lockst", 32'(lock_status), 0);
        chk("loss_count", 32'(loss_count), 1);

        samples(15, 16'd50);
        samples(1, 16'd200);
        samples(15, 16'd50);
        chk("cnt_reset_gear", 32'(gear), 0);
        samples(1, 16'd50);
        chk("settle_gear", 32'(gear), 1);
        samples(1, 16'hfe6f);
        chk("settle_fallback", 32'(gear), 0);

        lock_thresh = 16'd32767;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 16'h8000);
            step(1'b1, 1'b0, 16'h8000);
            step(1'b1, 1'b0, 16'd0);
        end
        chk("sat_gap_gear", 32'(gear), 1);
        lock_thresh = 16'd100;
        samples(16, 16'hffce);
        chk("neg_lock", 32'(lock_status), 1);
        step(1'b0, 1'b1, 16'd50);
        chk("abort_gear", 32'(gear), 0);
        chk("abort_chg", 32'(gear_chg), 1);
        step(1'b1, 1'b0, 16'd0);
        samples(32, 16'd50);
        chk("relock_gear", 32'(gear), 2);
        pulse_reset();

        step(1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 258; k++) begin
            samples(32, 16'd10);
            samples(4, 16'd900);
        end
        chk("loss_sat", 32'(loss_count), 255);
        pulse_reset();

        for (int i = 0; i < 3000; i++) begin
            logic        en, v;
            logic [15:0] pe;
            if (i % 500 == 0) begin
                lock_thresh   = 16'($urandom_range(20, 300));
                unlock_thresh = 16'($urandom_range(10, 600));
            end
            en = ($urandom_range(0, 99) < 97);
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 85)
                pe = 16'($urandom_range(0, 20));
            else if ($urandom_range(0, 9) == 0)
                pe = 16'h8000;
            else
                pe = 16'($urandom_range(0, 700));
            if ($urandom_range(0, 1) == 1) pe = -pe;
            step(en, v, pe);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
